// File: rtl/alpha_pkg.sv
// Shared defaults and types for the alpha gain-select block.
package alpha_pkg;

    localparam int DATA_W_DEF = 9;
    localparam int TMO_W_DEF  = 5;

    // Magnitude of a default-width sample; |-256| = 256 still fits unsigned.
    typedef logic [DATA_W_DEF-1:0] mag_t;

endpackage

// File: rtl/alpha_timeout_counter.sv
// Saturating release-timeout counter with mask-match detection.
module alpha_timeout_counter
    import alpha_pkg::*;
#(
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             incr,
    input  logic [TMO_W-1:0] mask,
    output logic [TMO_W-1:0] count,
    output logic             match
);

    localparam logic [TMO_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (incr && (count != CNT_MAX)) begin
            count <= count + TMO_W'(1);
        end
    end

    // Release is due once every bit selected by the mask is set in the count.
    assign match = ((count & mask) == mask);

endmodule

// File: rtl/alpha_block_v2.sv
// Gain-select flag with attack on large magnitude and masked release timeout.
module alpha_block_v2
    import alpha_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TMO_W  = TMO_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_sampling,
    input  logic [DATA_W-1:0] hdr_current_value,
    input  logic [DATA_W-1:0] threshold_high,
    input  logic [DATA_W-1:0] threshold_low,
    input  logic [TMO_W-1:0]  timeout_mask,
    output logic              alpha
);

    function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] u;
        u = v;
        return v[DATA_W-1] ? (~u + DATA_W'(1)) : u;
    endfunction

    logic signed [DATA_W-1:0] hdr_s;
    logic [DATA_W-1:0]        mag;
    logic                     attack;
    logic                     below_low;
    logic                     cnt_clear;
    logic                     cnt_incr;
    logic                     cnt_match;
    logic [TMO_W-1:0]         cnt;
    logic                     alpha_next;

    assign hdr_s     = $signed(hdr_current_value);
    assign mag       = abs_mag(hdr_s);
    assign attack    = (mag > threshold_high);
    assign below_low = (mag < threshold_low);

    // Attack wins over release even when the thresholds are inverted.
    always_comb begin
        alpha_next = alpha;
        cnt_clear  = 1'b0;
        cnt_incr   = 1'b0;
        if (enable_sampling) begin
            if (attack) begin
                alpha_next = 1'b1;
                cnt_clear  = 1'b1;
            end else if (alpha && below_low) begin
                if (cnt_match) begin
                    alpha_next = 1'b0;
                    cnt_clear  = 1'b1;
                end else begin
                    cnt_incr = 1'b1;
                end
            end else begin
                cnt_clear = 1'b1;
            end
        end
    end

    alpha_timeout_counter #(
        .TMO_W (TMO_W)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .incr  (cnt_incr),
        .mask  (timeout_mask),
        .count (cnt),
        .match (cnt_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            alpha <= 1'b0;
        end else begin
            alpha <= alpha_next;
        end
    end

endmodule

// File: tb/tb_alpha_block_v2.sv
// Table-driven scoreboard bench for alpha_block_v2.
module tb_alpha_block_v2;

    localparam int DATA_W = 9;
    localparam int TMO_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable_sampling;
    logic [DATA_W-1:0] hdr_current_value;
    logic [DATA_W-1:0] threshold_high;
    logic [DATA_W-1:0] threshold_low;
    logic [TMO_W-1:0]  timeout_mask;
    logic              alpha;

    always #5 clk = ~clk;

    alpha_block_v2 #(
        .DATA_W (DATA_W),
        .TMO_W  (TMO_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable_sampling   (enable_sampling),
        .hdr_current_value (hdr_current_value),
        .threshold_high    (threshold_high),
        .threshold_low     (threshold_low),
        .timeout_mask      (timeout_mask),
        .alpha             (alpha)
    );

    typedef struct {
        int   hdr;
        int   th_h;
        int   th_l;
        int   mask;
        logic exp;
    } vec_t;

    vec_t tbl[$];
    logic exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(int hdr, int th_h, int th_l, int mask, logic exp, int n);
        vec_t v;
        v.hdr  = hdr;
        v.th_h = th_h;
        v.th_l = th_l;
        v.mask = mask;
        v.exp  = exp;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic strobe(vec_t v, string tag);
        logic e;
        @(negedge clk);
        hdr_current_value = v.hdr[DATA_W-1:0];
        threshold_high    = v.th_h[DATA_W-1:0];
        threshold_low     = v.th_l[DATA_W-1:0];
        timeout_mask      = v.mask[TMO_W-1:0];
        enable_sampling   = 1'b1;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, " strobe"}, int'(alpha), int'(e));
        @(negedge clk);
        enable_sampling = 1'b0;
        // Large samples between strobes must be ignored.
        hdr_current_value = 9'sd255;
        repeat (6) @(negedge clk);
        check({tag, " hold"}, int'(alpha), int'(e));
    endtask

    task automatic pulse_reset(logic en, int hdr, string tag);
        @(negedge clk);
        reset             = 1'b1;
        enable_sampling   = en;
        hdr_current_value = hdr[DATA_W-1:0];
        threshold_high    = 9'd200;
        threshold_low     = 9'd50;
        @(posedge clk);
        #1;
        check({tag, " alpha"}, int'(alpha), 0);
        check({tag, " count"}, int'(dut.u_timeout.count), 0);
        @(negedge clk);
        reset           = 1'b0;
        enable_sampling = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        reset             = 1'b1;
        enable_sampling   = 1'b0;
        hdr_current_value = '0;
        threshold_high    = 9'd200;
        threshold_low     = 9'd50;
        timeout_mask      = 5'b10000;
        repeat (3) @(posedge clk);
        #1;
        check("reset alpha", int'(alpha), 0);
        check("reset count", int'(dut.u_timeout.count), 0);
        @(negedge clk);
        reset = 1'b0;

        add(100,  200, 50, 16, 1'b0, 10);
        add(210,  200, 50, 16, 1'b1, 1);
        add(200,  200, 50, 16, 1'b1, 1);
        add(40,   200, 50, 16, 1'b1, 16);
        add(40,   200, 50, 16, 1'b0, 1);
        add(210,  200, 50, 16, 1'b1, 1);
        add(40,   200, 50, 16, 1'b1, 10);
        add(70,   200, 50, 16, 1'b1, 1);
        add(40,   200, 50, 16, 1'b1, 16);
        add(40,   200, 50, 16, 1'b0, 1);
        add(-205, 200, 50, 16, 1'b1, 1);
        add(-12,  200, 50, 16, 1'b1, 16);
        add(-12,  200, 50, 16, 1'b0, 1);
        add(-200, 200, 50, 16, 1'b0, 1);
        add(-256, 200, 50, 16, 1'b1, 1);
        add(12,   200, 50, 0,  1'b0, 1);
        add(120,  100, 150, 0, 1'b1, 1);
        add(80,   100, 150, 0, 1'b0, 1);
        add(210,  255, 50, 16, 1'b0, 1);
        add(210,  200, 50, 3,  1'b1, 1);
        add(40,   200, 50, 3,  1'b1, 3);
        add(40,   200, 50, 3,  1'b0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            strobe(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset while a partial timeout is pending.
        begin
            vec_t v;
            v.th_h = 200; v.th_l = 50; v.mask = 16;
            v.hdr = 210; v.exp = 1'b1;
            strobe(v, "mid attack");
            v.hdr = 40;
            for (int i = 0; i < 10; i++) strobe(v, $sformatf("mid cnt%0d", i));
            check("mid count10", int'(dut.u_timeout.count), 10);
            pulse_reset(1'b0, 40, "mid reset");
            v.hdr = 40; v.exp = 1'b0;
            strobe(v, "post reset low");
            pulse_reset(1'b1, 210, "reset with strobe");
            v.hdr = 210; v.exp = 1'b1;
            strobe(v, "resume attack");
            v.hdr = 12; v.mask = 0; v.exp = 1'b0;
            strobe(v, "mask0 release");
        end

        check("scoreboard empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alpha_block_v2.md
ALPHA_BLOCK_V2 -- requirements
Module: alpha_block_v2

Interface
REQ-001 Parameter DATA_W, default 9: width of the sample and threshold inputs.
REQ-002 Parameter TMO_W, default 5: width of the timeout mask and timeout counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable_sampling  input  1  sample strobe, one clk cycle wide, nominally every 8 clks; all decisions occur only on cycles where it is high.
REQ-006 hdr_current_value  input  DATA_W  current HDR sample, two's-complement signed.
REQ-007 threshold_high  input  DATA_W  unsigned upper magnitude threshold.
REQ-008 threshold_low  input  DATA_W  unsigned lower magnitude threshold.
REQ-009 timeout_mask  input  TMO_W  selects the release timeout length.
REQ-010 alpha  output  1  registered gain-select flag: 1 = large-signal (attenuated) mode, 0 = normal mode.

Function
REQ-011 mag = |hdr_current_value|, computed as DATA_W-bit unsigned; -256 yields 256 with no overflow.
REQ-012 Inputs are sampled only on clk edges where enable_sampling=1; on all other cycles alpha and the counter hold.
REQ-013 Attack: on a strobe with mag > threshold_high, alpha<=1 and the counter clears; this applies regardless of the current alpha value.
REQ-014 Equality mag == threshold_high does not trigger attack.
REQ-015 Release counting: on a strobe with alpha=1 and mag < threshold_low, the counter increments, saturating at 2^TMO_W-1.
REQ-016 Release: if that strobe's pre-increment count satisfies (cnt & timeout_mask) == timeout_mask, alpha<=0 and the counter clears instead of incrementing.
REQ-017 With timeout_mask=0, the first below-low strobe releases.
REQ-018 With timeout_mask=5'b10000, release happens on the 17th consecutive below-low strobe.
REQ-019 Hysteresis band: on a strobe with threshold_low <= mag <= threshold_high, alpha holds and the counter clears, so the release requires consecutive below-low strobes.
REQ-020 On a strobe with alpha=0 and mag <= threshold_high, alpha stays 0 and the counter stays 0.
REQ-021 Latency: alpha changes on the same clk edge that samples the qualifying strobe, i.e. it is visible one cycle after the strobe is asserted.
REQ-022 Threshold and mask values are used as presented on each strobe; mid-run changes take effect at the next strobe.
REQ-023 If threshold_low > threshold_high, REQ-013 takes priority over REQ-015/016.

Reset
REQ-024 When reset=1 at a clk edge: alpha<=0 and counter<=0, regardless of enable_sampling.
REQ-025 Reset asserted mid-count discards any partial timeout.
REQ-026 Normal operation resumes at the first strobe after reset deasserts.

Structure
REQ-027 Shared package alpha_pkg holds DATA_W/TMO_W defaults and a magnitude typedef.
REQ-028 One sub-module, alpha_timeout_counter, contains the saturating counter, its clear/increment controls, and the mask-match output; the abs/compare logic and the alpha flop stay in the top module.

Verification (strobe every 8 clks, th_high=200, th_low=50, mask=5'b10000)
REQ-029 Reset, then hdr=100 for 10 strobes -> alpha remains 0.
REQ-030 hdr=210 -> alpha=1 one clk after the strobe; then hdr=200 -> alpha stays 1 (equality, no attack, no release).
REQ-031 From alpha=1, hdr=40 held -> alpha falls on the 17th strobe; alpha=1 throughout strobes 1-16.
REQ-032 From alpha=1: hdr=40 for 10 strobes, hdr=70 for 1 strobe, then hdr=40 -> the release needs 17 further strobes (counter cleared).
REQ-033 Negative samples: hdr=-12 -> counts as below-low; hdr=-205 -> alpha=1; hdr=-256 -> alpha=1.
REQ-034 Assert reset while the counter is at 10 -> alpha=0 and counter=0 next clk; mask=0 with alpha=1 and hdr=12 -> release on the first strobe.
